// File: rtl/map_sensor_scan.sv
`default_nettype none
// ============================================================================
// Module   : map_sensor_scan
// Purpose  : Reads the map tile under the bot plus its four orthogonal
//            neighbours over ROM port B and returns them as one result.
// Revision : 1.0
// ============================================================================
module map_sensor_scan #(
   parameter int unsigned READ_LAT     = 1,
   parameter logic [1:0]  OFF_MAP_CODE = 2'b10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [6:0]  i_loc_x,
   input  logic [6:0]  i_loc_y,
   output logic        o_ready,
   output logic        o_done,
   output logic [1:0]  o_tile_c,
   output logic [1:0]  o_tile_n,
   output logic [1:0]  o_tile_e,
   output logic [1:0]  o_tile_s,
   output logic [1:0]  o_tile_w,
   output logic [13:0] o_addrb,
   input  logic [1:0]  i_doutb
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_WAIT = 3'd2,
      S_CAPT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [1:0] c_WAIT_LAST = 2'(READ_LAT - 1);
   localparam logic [2:0] c_LAST_STEP = 3'd4;

   state_t      r_state;
   state_t      w_next;
   logic [6:0]  r_x;
   logic [6:0]  r_y;
   logic [2:0]  r_k;
   logic [1:0]  r_wcnt;
   logic [13:0] r_addrb;
   logic        r_done;
   logic [1:0]  r_sh_c, r_sh_n, r_sh_e, r_sh_s, r_sh_w;
   logic [1:0]  r_tile_c, r_tile_n, r_tile_e, r_tile_s, r_tile_w;

   logic        w_off;
   logic [6:0]  w_nx;
   logic [6:0]  w_ny;
   logic [1:0]  w_code;

   // Neighbour coordinate for step k; w_off flags a step that would leave the map.
   always_comb begin
      w_nx  = r_x;
      w_ny  = r_y;
      w_off = 1'b0;
      case (r_k)
         3'd1: begin w_ny = r_y - 7'd1; w_off = (r_y == 7'd0);   end
         3'd2: begin w_nx = r_x + 7'd1; w_off = (r_x == 7'd127); end
         3'd3: begin w_ny = r_y + 7'd1; w_off = (r_y == 7'd127); end
         3'd4: begin w_nx = r_x - 7'd1; w_off = (r_x == 7'd0);   end
         default: ;
      endcase
   end

   assign w_code = w_off ? OFF_MAP_CODE : i_doutb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_req) w_next = S_ADDR;
         S_ADDR: w_next = S_WAIT;
         S_WAIT: if (r_wcnt == c_WAIT_LAST) w_next = S_CAPT;
         S_CAPT: w_next = (r_k == c_LAST_STEP) ? S_DONE : S_ADDR;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x      <= 7'd0;
         r_y      <= 7'd0;
         r_k      <= 3'd0;
         r_wcnt   <= 2'd0;
         r_addrb  <= 14'd0;
         r_done   <= 1'b0;
         r_sh_c   <= 2'b00;
         r_sh_n   <= 2'b00;
         r_sh_e   <= 2'b00;
         r_sh_s   <= 2'b00;
         r_sh_w   <= 2'b00;
         r_tile_c <= 2'b00;
         r_tile_n <= 2'b00;
         r_tile_e <= 2'b00;
         r_tile_s <= 2'b00;
         r_tile_w <= 2'b00;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_x <= i_loc_x;
                  r_y <= i_loc_y;
                  r_k <= 3'd0;
               end
            end
            S_ADDR: begin
               // Off-map steps park the address on the centre tile instead of wrapping.
               r_addrb <= w_off ? {r_y, r_x} : {w_ny, w_nx};
               r_wcnt  <= 2'd0;
            end
            S_WAIT: r_wcnt <= r_wcnt + 2'd1;
            S_CAPT: begin
               case (r_k)
                  3'd0:    r_sh_c <= w_code;
                  3'd1:    r_sh_n <= w_code;
                  3'd2:    r_sh_e <= w_code;
                  3'd3:    r_sh_s <= w_code;
                  default: r_sh_w <= w_code;
               endcase
               if (r_k != c_LAST_STEP) r_k <= r_k + 3'd1;
            end
            S_DONE: begin
               r_tile_c <= r_sh_c;
               r_tile_n <= r_sh_n;
               r_tile_e <= r_sh_e;
               r_tile_s <= r_sh_s;
               r_tile_w <= r_sh_w;
            end
            default: ;
         endcase
      end
   end

   assign o_ready  = (r_state == S_IDLE);
   assign o_done   = r_done;
   assign o_addrb  = r_addrb;
   assign o_tile_c = r_tile_c;
   assign o_tile_n = r_tile_n;
   assign o_tile_e = r_tile_e;
   assign o_tile_s = r_tile_s;
   assign o_tile_w = r_tile_w;

endmodule
`default_nettype wire

// File: tb/tb_map_sensor_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_sensor_scan
// Purpose  : Scoreboard bench driving a READ_LAT=1 and a READ_LAT=2 scanner
//            side by side against a tile-level reference model.
// Revision : 1.0
// ============================================================================
module tb_map_sensor_scan;

   localparam logic [1:0] c_OFF = 2'b10;

   typedef struct {
      int          due;
      logic [9:0]  tiles;
   } done_exp_t;

   typedef struct {
      int          due;
      logic [13:0] addr;
   } addr_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [6:0]  lx;
   logic [6:0]  ly;
   logic        ready [2];
   logic        done  [2];
   logic [1:0]  tc [2];
   logic [1:0]  tn [2];
   logic [1:0]  te [2];
   logic [1:0]  ts [2];
   logic [1:0]  tw [2];
   logic [13:0] addr [2];
   logic [1:0]  p1 [2];
   logic [1:0]  p2 [2];
   logic [1:0]  rom [16384];

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          lat_t [2];
   int          step_p [2];
   int          free_at [2];
   int          last_acc [2];
   logic [9:0]  exp_tiles [2];
   done_exp_t   dq [2][$];
   addr_exp_t   aq [2][$];
   int          dx [5] = '{0, 0, 1, 0, -1};
   int          dy [5] = '{0, -1, 0, 1, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM port B models: one and two cycles of read latency.
   always @(posedge clk) begin
      p1[0] <= rom[addr[0]];
      p1[1] <= rom[addr[1]];
      p2[1] <= p1[1];
   end

   map_sensor_scan #(.READ_LAT(1), .OFF_MAP_CODE(c_OFF)) u_dut1 (
      .clk(clk), .reset(reset), .i_req(req), .i_loc_x(lx), .i_loc_y(ly),
      .o_ready(ready[0]), .o_done(done[0]),
      .o_tile_c(tc[0]), .o_tile_n(tn[0]), .o_tile_e(te[0]), .o_tile_s(ts[0]), .o_tile_w(tw[0]),
      .o_addrb(addr[0]), .i_doutb(p1[0])
   );

   map_sensor_scan #(.READ_LAT(2), .OFF_MAP_CODE(c_OFF)) u_dut2 (
      .clk(clk), .reset(reset), .i_req(req), .i_loc_x(lx), .i_loc_y(ly),
      .o_ready(ready[1]), .o_done(done[1]),
      .o_tile_c(tc[1]), .o_tile_n(tn[1]), .o_tile_e(te[1]), .o_tile_s(ts[1]), .o_tile_w(tw[1]),
      .o_addrb(addr[1]), .i_doutb(p2[1])
   );

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h", name, d, cyc, act, exp_v);
      end
   endtask

   function automatic logic [9:0] tiles_of(input int d);
      return {tc[d], tn[d], te[d], ts[d], tw[d]};
   endfunction

   function automatic bit on_map(input int x, input int y);
      return (x >= 0) && (x <= 127) && (y >= 0) && (y <= 127);
   endfunction

   // Reference: tile code under (x,y)+offset k, or the off-map code.
   function automatic logic [1:0] code_k(input int x, input int y, input int k);
      int nx = x + dx[k];
      int ny = y + dy[k];
      if (!on_map(nx, ny)) return c_OFF;
      return rom[ny * 128 + nx];
   endfunction

   function automatic logic [13:0] addr_k(input int x, input int y, input int k);
      int nx = x + dx[k];
      int ny = y + dy[k];
      if (!on_map(nx, ny)) return 14'(y * 128 + x);
      return 14'(ny * 128 + nx);
   endfunction

   task automatic accept(input int d, input int x, input int y);
      done_exp_t e;
      addr_exp_t a;
      int        acc = cyc + 1;
      e.due   = acc + lat_t[d];
      e.tiles = {code_k(x, y, 0), code_k(x, y, 1), code_k(x, y, 2), code_k(x, y, 3), code_k(x, y, 4)};
      dq[d].push_back(e);
      for (int k = 0; k < 5; k++) begin
         a.due  = acc + 1 + k * step_p[d];
         a.addr = addr_k(x, y, k);
         aq[d].push_back(a);
      end
      last_acc[d] = acc;
      free_at[d]  = acc + lat_t[d];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input int x, input int y);
      req = r;
      lx  = 7'(x);
      ly  = 7'(y);
      if (r) begin
         for (int d = 0; d < 2; d++) begin
            if (cyc >= free_at[d]) accept(d, x, y);
         end
      end
      tick();
   endtask

   task automatic idle_until_free();
      while (cyc < free_at[0] || cyc < free_at[1])
         drive(1'b0, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      drive(1'b0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         dq[d].delete();
         aq[d].delete();
         free_at[d]   = 0;
         last_acc[d]  = 0;
         exp_tiles[d] = 10'd0;
      end
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   function automatic int rnd_coord();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return 127;
         default: return int'($urandom_range(0, 127));
      endcase
   endfunction

   // Monitor: compares outputs at the falling edge against queued expectations.
   initial begin
      done_exp_t e;
      addr_exp_t a;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (reset) begin
               chk("rst_ready", d, 32'(ready[d]), 32'd1);
               chk("rst_done",  d, 32'(done[d]),  32'd0);
               chk("rst_addrb", d, 32'(addr[d]),  32'd0);
               chk("rst_tiles", d, 32'(tiles_of(d)), 32'd0);
            end else begin
               chk("ready", d, 32'(ready[d]), 32'((cyc < last_acc[d]) || (cyc >= free_at[d])));
               while (aq[d].size() > 0 && aq[d][0].due <= cyc) begin
                  a = aq[d].pop_front();
                  if (a.due == cyc) chk("addrb", d, 32'(addr[d]), 32'(a.addr));
                  else              chk("addrb_sched", d, 32'(cyc), 32'(a.due));
               end
               if (dq[d].size() > 0 && dq[d][0].due == cyc) begin
                  e = dq[d].pop_front();
                  chk("done_latency", d, 32'(done[d]), 32'd1);
                  chk("tiles", d, 32'(tiles_of(d)), 32'(e.tiles));
                  exp_tiles[d] = e.tiles;
               end else begin
                  chk("done_idle", d, 32'(done[d]), 32'd0);
                  chk("tiles_hold", d, 32'(tiles_of(d)), 32'(exp_tiles[d]));
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      req   = 1'b0;
      lx    = 7'd0;
      ly    = 7'd0;
      for (int d = 0; d < 2; d++) begin
         step_p[d]    = 2 + (d + 1);
         lat_t[d]     = 5 * step_p[d] + 1;
         free_at[d]   = 0;
         last_acc[d]  = 0;
         exp_tiles[d] = 10'd0;
      end
      for (int i = 0; i < 16384; i++) rom[i] = 2'($urandom_range(0, 3));
      rom[20 * 128 + 10] = 2'b01;
      rom[19 * 128 + 10] = 2'b10;
      rom[20 * 128 + 11] = 2'b00;
      rom[21 * 128 + 10] = 2'b01;
      rom[20 * 128 + 9]  = 2'b10;
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Interior scan and map corners/edges.
      drive(1'b1, 10, 20);   idle_until_free();
      drive(1'b1, 0, 0);     idle_until_free();
      drive(1'b1, 127, 127); idle_until_free();
      drive(1'b1, 0, 127);   idle_until_free();
      drive(1'b1, 127, 0);   idle_until_free();

      // A second request mid-scan must be dropped.
      drive(1'b1, 5, 5);
      repeat (4) drive(1'b0, 0, 0);
      drive(1'b1, 60, 60);
      idle_until_free();

      // Held-high request with a moving location: back-to-back scans.
      for (int i = 0; i < 70; i++) drive(1'b1, rnd_coord(), rnd_coord());
      idle_until_free();

      // Abort mid-scan, then a fresh scan.
      drive(1'b1, 40, 50);
      repeat (6) drive(1'b0, 0, 0);
      do_reset();
      drive(1'b1, 41, 51);
      idle_until_free();

      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 3) == 0, rnd_coord(), rnd_coord());
      idle_until_free();
      repeat (30) drive(1'b0, 0, 0);

      for (int d = 0; d < 2; d++) chk("drain", d, 32'(dq[d].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
